// File: rtl/cmd_dispatch.sv
// cmd_dispatch: sequences UART_wrapper commands against an 8x8 register file and an LED register
// Ports: clk, rst_n (async active-low); cmd_rdy/cmd in from the wrapper, clr_cmd_rdy acknowledges;
//        send_resp/resp launch a response byte, resp_sent closes it; LED register, busy, sticky err.
module cmd_dispatch #(
  parameter int TO_CYCLES = 100000,
  parameter logic [7:0] ACK = 8'hA5,
  parameter logic [7:0] NACK = 8'hEE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_rdy,
  input  logic [15:0] cmd,
  input  logic        resp_sent,
  output logic        clr_cmd_rdy,
  output logic        send_resp,
  output logic [7:0]  resp,
  output logic [7:0]  LED,
  output logic        busy,
  output logic        err
);
  localparam int CW = $clog2(TO_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, EXEC, WAIT} state_t;
  state_t state_q, state_d;
  logic [15:0] cmd_q, cmd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] regs_q [8];
  logic [7:0] regs_d [8];
  logic clr_q, clr_d, send_q, send_d, busy_q, busy_d, err_q, err_d;
  logic [7:0] resp_q, resp_d, led_q, led_d;
  logic [3:0] op, addr;
  logic [7:0] data;
  logic ok;
  assign op = cmd_q[15:12];
  assign addr = cmd_q[11:8];
  assign data = cmd_q[7:0];
  assign ok = !addr[3];
  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    cnt_d = cnt_q;
    regs_d = regs_q;
    clr_d = 1'b0;
    send_d = 1'b0;
    resp_d = resp_q;
    led_d = led_q;
    err_d = err_q;
    case (state_q)
      // the wrapper may still show cmd_rdy on the edge after our clear
      IDLE: if (cmd_rdy && !clr_q) begin
        cmd_d = cmd;
        clr_d = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        send_d = 1'b1;
        cnt_d = '0;
        state_d = WAIT;
        case (op)
          4'h1: begin
            if (ok) regs_d[addr[2:0]] = data;
            resp_d = ok ? ACK : NACK;
          end
          4'h2: resp_d = ok ? regs_q[addr[2:0]] : NACK;
          4'h3: begin
            led_d = data;
            resp_d = ACK;
          end
          4'h4: resp_d = data;
          default: resp_d = NACK;
        endcase
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // resp_sent wins over a coincident terminal count
        if (resp_sent) state_d = IDLE;
        else if (cnt_q == CW'(TO_CYCLES - 1)) begin
          err_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmd_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
      clr_q <= 1'b0;
      send_q <= 1'b0;
      resp_q <= '0;
      led_q <= '0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      cnt_q <= cnt_d;
      regs_q <= regs_d;
      clr_q <= clr_d;
      send_q <= send_d;
      resp_q <= resp_d;
      led_q <= led_d;
      busy_q <= busy_d;
      err_q <= err_d;
    end
  end
  assign clr_cmd_rdy = clr_q;
  assign send_resp = send_q;
  assign resp = resp_q;
  assign LED = led_q;
  assign busy = busy_q;
  assign err = err_q;
endmodule

// File: tb/tb_cmd_dispatch.sv
// tb_cmd_dispatch: scoreboard bench for cmd_dispatch with directed commands
module tb_cmd_dispatch;
  logic clk = 1'b0, rst_n = 1'b0, cmd_rdy = 1'b0, resp_sent = 1'b0;
  logic [15:0] cmd = '0;
  logic clr_cmd_rdy, send_resp, busy, err;
  logic [7:0] resp, LED;
  int checks = 0, errors = 0, npush = 0, nclr = 0, nsend = 0, wc;
  logic [7:0] q [$];
  logic prev_clr = 1'b0;
  cmd_dispatch #(.TO_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_rdy(cmd_rdy), .cmd(cmd), .resp_sent(resp_sent),
    .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp), .LED(LED),
    .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      if (clr_cmd_rdy) begin
        nclr++;
        chk("no_double_clr", {31'b0, prev_clr}, 0);
      end
      if (send_resp) begin
        nsend++;
        chk("send_after_clr", {31'b0, prev_clr}, 1);
        chk("queue_nonempty", {31'b0, q.size() != 0}, 1);
        if (q.size() != 0) chk("resp", {24'b0, resp}, {24'b0, q.pop_front()});
      end
      prev_clr = clr_cmd_rdy;
    end else prev_clr = 1'b0;
  end
  task automatic issue(input logic [15:0] c, input logic [7:0] e, input int gap, input bit hold,
                       output int wait_cyc);
    @(negedge clk);
    cmd = c;
    cmd_rdy = 1'b1;
    q.push_back(e);
    npush++;
    for (int i = 0; i < 20 && !clr_cmd_rdy; i++) @(negedge clk);
    chk("clr_seen", {31'b0, clr_cmd_rdy}, 1);
    if (!hold) cmd_rdy = 1'b0;
    @(negedge clk);
    chk("send_seen", {31'b0, send_resp}, 1);
    wait_cyc = 0;
    if (gap >= 0) begin
      repeat (gap) @(negedge clk);
      resp_sent = 1'b1;
      @(negedge clk);
      resp_sent = 1'b0;
    end
    for (int i = 0; i < 40 && busy; i++) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("idle_return", {31'b0, busy}, 0);
    cmd_rdy = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_clr", {31'b0, clr_cmd_rdy}, 0);
    chk("rst_send", {31'b0, send_resp}, 0);
    chk("rst_resp", {24'b0, resp}, 0);
    chk("rst_led", {24'b0, LED}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_err", {31'b0, err}, 0);
    rst_n = 1'b1;
    issue(16'h1255, 8'hA5, 5, 0, wc);
    issue(16'h2200, 8'h55, 2, 0, wc);
    issue(16'h2A00, 8'hEE, 1, 0, wc);
    issue(16'h1A11, 8'hEE, 0, 0, wc);
    issue(16'h3C3C, 8'hA5, 1, 0, wc);
    chk("led_set", {24'b0, LED}, 32'h3C);
    issue(16'h4077, 8'h77, 0, 0, wc);
    issue(16'h9000, 8'hEE, 0, 0, wc);
    chk("led_kept", {24'b0, LED}, 32'h3C);
    issue(16'h2200, 8'h55, 0, 0, wc);
    issue(16'h1566, 8'hA5, 3, 1, wc);
    issue(16'h2500, 8'h66, 0, 0, wc);
    issue(16'h4011, 8'h11, 15, 0, wc);
    chk("same_edge_no_err", {31'b0, err}, 0);
    issue(16'h4022, 8'h22, -1, 0, wc);
    chk("timeout_cycles", wc, 16);
    chk("timeout_err", {31'b0, err}, 1);
    issue(16'h4033, 8'h33, 2, 0, wc);
    chk("err_sticky", {31'b0, err}, 1);
    @(negedge clk);
    cmd = 16'h1799;
    cmd_rdy = 1'b1;
    q.push_back(8'hA5);
    npush++;
    @(negedge clk);
    cmd_rdy = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_wait_busy", {31'b0, busy}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_clr", {31'b0, clr_cmd_rdy}, 0);
    chk("arst_send", {31'b0, send_resp}, 0);
    chk("arst_resp", {24'b0, resp}, 0);
    chk("arst_led", {24'b0, LED}, 0);
    chk("arst_busy", {31'b0, busy}, 0);
    chk("arst_err", {31'b0, err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'h2200, 8'h00, 0, 0, wc);
    issue(16'h2700, 8'h00, 0, 0, wc);
    chk("led_after_rst", {24'b0, LED}, 0);
    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    chk("clr_count", nclr, npush);
    chk("send_count", nsend, npush);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cmd_dispatch.md
# cmd_dispatch

Command dispatcher that sits behind `UART_wrapper` and sequences its receive/response handshakes. It latches each received 16-bit command, clears the wrapper's `cmd_rdy`, and executes the opcode against an 8-entry x 8-bit register file and an LED register. It then issues a one-byte response and waits for `resp_sent`, with a timeout guard.

## Interface

- `TO_CYCLES`, default 100000: max cycles in WAIT for `resp_sent` before abort; counter width `$clog2(TO_CYCLES+1)`.
- `ACK`, default 8'hA5: response byte for a successful write or LED command.
- `NACK`, default 8'hEE: response byte for an illegal opcode or address.
- `clk`  input  1  system clock; all state changes on its rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `cmd_rdy`  input  1  wrapper holds high while `cmd` is valid, until cleared.
- `cmd`  input  16  received command: `[15:12]` opcode, `[11:8]` addr, `[7:0]` data.
- `resp_sent`  input  1  one-cycle pulse from the wrapper when the response byte has been transmitted.
- `clr_cmd_rdy`  output  1  one-cycle pulse acknowledging consumption of `cmd`.
- `send_resp`  output  1  one-cycle pulse launching transmission of `resp`.
- `resp`  output  8  response byte; held stable from `send_resp` until exit from WAIT.
- `LED`  output  8  LED register.
- `busy`  output  1  high in EXEC and WAIT.
- `err`  output  1  sticky; set on timeout, cleared only by reset.

## Operation

- States: IDLE, EXEC, WAIT. All outputs are registered.
- **IDLE:** when `cmd_rdy`=1, load `cmd_q`<=`cmd`, pulse `clr_cmd_rdy`, and go to EXEC. Otherwise stay in IDLE.
- **EXEC** (exactly 1 cycle): decode `cmd_q`, load `resp`, pulse `send_resp`, clear the timeout counter, and go to WAIT.
  - Opcode 4'h1, WRITE: if `addr[3]`=0, `regs[addr[2:0]]`<=data and `resp`=ACK. Otherwise no write and `resp`=NACK.
  - Opcode 4'h2, READ: if `addr[3]`=0, `resp`=`regs[addr[2:0]]`. Otherwise `resp`=NACK.
  - Opcode 4'h3, LED: `LED`<=data and `resp`=ACK; addr is ignored.
  - Opcode 4'h4, ECHO: `resp`=data.
  - Any other opcode: `resp`=NACK with no side effects.
- **WAIT:** the counter increments each cycle.
  - `resp_sent`=1 returns to IDLE.
  - Counter reaching `TO_CYCLES`-1 without `resp_sent` sets `err` and returns to IDLE.
- Register-file writes and `LED` updates occur only in EXEC.

## Timing

- Reset values: state=IDLE, `clr_cmd_rdy`=0, `send_resp`=0, `resp`=8'h00, `LED`=8'h00, `busy`=0, `err`=0, all `regs`=8'h00, counter=0.
- Edge k samples `cmd_rdy`=1 in IDLE, so `clr_cmd_rdy` is high for cycle k..k+1.
- Edge k+1 (EXEC): `resp`, register-file and `LED` updates become visible, and `send_resp` is high for cycle k+1..k+2.
- Edge k+2 onward: WAIT.
- Minimum command-to-command spacing is 4 edges: IDLE, EXEC, WAIT, then IDLE again.
- `cmd_rdy` while `busy` is ignored and not latched. It is picked up on the first IDLE edge where it is still high.
- `resp_sent` outside WAIT is ignored.
- `resp_sent` on the same edge as the timeout terminal count counts as success: `err` is not set.
- `cmd_rdy` still high on the edge after `clr_cmd_rdy` (wrapper clear latency) must not cause a double dispatch. IDLE therefore requires `clr_cmd_rdy`=0 in the previous cycle before accepting.
- Asynchronous reset mid-WAIT or mid-EXEC returns immediately to the reset values. A partially executed command has no effect unless its EXEC edge already occurred.
- `resp` retains its last value in IDLE.

## Test plan

- Reset, then `cmd`=16'h1255 with a `cmd_rdy` pulse, then `resp_sent` 5 cycles later -> `clr_cmd_rdy` pulse, `send_resp` one edge later, `resp`=8'hA5, `regs[2]`=8'h55, back to IDLE.
- WRITE 16'h1255, then READ 16'h2200 -> second response `resp`=8'h55. READ 16'h2A00 -> `resp`=8'hEE.
- `cmd`=16'h3C3C -> `LED`=8'h3C and `resp`=8'hA5. `cmd`=16'h4077 -> `resp`=8'h77. `cmd`=16'h9000 -> `resp`=8'hEE, and `LED` and `regs` are unchanged.
- With `TO_CYCLES`=16 and `resp_sent` never asserted -> `err`=1 after 16 WAIT cycles, then IDLE. The next command still executes normally and `err` stays 1.
- Hold `cmd_rdy` high continuously through one command -> exactly one `clr_cmd_rdy` and one `send_resp` per accepted command. No second dispatch occurs in the cycle after the clear.
- Assert `rst_n`=0 during WAIT -> all outputs take their reset values asynchronously, and `regs` and `LED` are cleared.
